// File: rtl/prirv32_mem_arbiter.sv
// prirv32_mem_arbiter: shares the single priRV32 memory port between the
// instruction fetch unit (IF) and the load/store unit (LS). LS has default
// priority; a starvation counter forces an IF win after STARVE_MAX
// consecutive LS wins over a pending fetch.
// Optional feature: define PRIRV32_ARB_TIMEOUT_EN to abort a transfer that
// waits TIMEOUT cycles without mem_ack_i (reported through err_o).
module prirv32_mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_n,
   input  logic                  if_req_i,
   input  logic [ADDR_W-1:0]     if_addr_i,
   output logic                  if_gnt_o,
   output logic                  if_rvalid_o,
   input  logic                  ls_req_i,
   input  logic                  ls_we_i,
   input  logic [ADDR_W-1:0]     ls_addr_i,
   input  logic [DATA_W-1:0]     ls_wdata_i,
   input  logic [DATA_W/8-1:0]   ls_be_i,
   output logic                  ls_gnt_o,
   output logic                  ls_rvalid_o,
   output logic [DATA_W-1:0]     rdata_o,
   output logic                  err_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_W-1:0]     mem_addr_o,
   output logic [DATA_W-1:0]     mem_wdata_o,
   output logic [DATA_W/8-1:0]   mem_be_o,
   input  logic                  mem_ack_i,
   input  logic [DATA_W-1:0]     mem_rdata_i
);

   localparam int BE_W  = DATA_W / 8;
   // Width never drops to zero, even when STARVE_MAX is 0 (IF always wins).
   localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_BUSY_IF = 2'd1;
   localparam logic [1:0] S_BUSY_LS = 2'd2;

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("prirv32_mem_arbiter: TIMEOUT must be at least 1");
   end

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  starve_q, starve_d;
   logic              if_gnt_q, if_gnt_d;
   logic              ls_gnt_q, ls_gnt_d;
   logic              if_rvalid_q, if_rvalid_d;
   logic              ls_rvalid_q, ls_rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [BE_W-1:0]   mem_be_q, mem_be_d;
   logic              if_wins;

`ifdef PRIRV32_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
   logic [TO_W-1:0]   to_q, to_d;
   logic              err_q, err_d;
`endif

   // IF takes a conflict only once LS has starved it STARVE_MAX times in a row.
   assign if_wins = if_req_i && (!ls_req_i || (starve_q == STARVE_LIM));

   // Next-state and output-register computation for the arbiter FSM.
   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      if_gnt_d    = 1'b0;
      ls_gnt_d    = 1'b0;
      if_rvalid_d = 1'b0;
      ls_rvalid_d = 1'b0;
      rdata_d     = rdata_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
`ifdef PRIRV32_ARB_TIMEOUT_EN
      to_d        = to_q;
      err_d       = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (if_wins) begin
               state_d    = S_BUSY_IF;
               starve_d   = '0;
               if_gnt_d   = 1'b1;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = if_addr_i;
               mem_be_d   = '1;
`ifdef PRIRV32_ARB_TIMEOUT_EN
               to_d       = '0;
`endif
            end else if (ls_req_i) begin
               state_d     = S_BUSY_LS;
               ls_gnt_d    = 1'b1;
               mem_req_d   = 1'b1;
               mem_we_d    = ls_we_i;
               mem_addr_d  = ls_addr_i;
               mem_wdata_d = ls_wdata_i;
               mem_be_d    = ls_be_i;
               if (if_req_i && (starve_q != STARVE_LIM)) begin
                  starve_d = starve_q + 1'b1;
               end
`ifdef PRIRV32_ARB_TIMEOUT_EN
               to_d        = '0;
`endif
            end
         end
         S_BUSY_IF, S_BUSY_LS: begin
            if (mem_ack_i) begin
               if (!mem_we_q) begin
                  rdata_d = mem_rdata_i;
               end
               mem_req_d   = 1'b0;
               if_rvalid_d = (state_q == S_BUSY_IF);
               ls_rvalid_d = (state_q == S_BUSY_LS);
               state_d     = S_IDLE;
            end
`ifdef PRIRV32_ARB_TIMEOUT_EN
            else if (to_q == TO_LAST) begin
               rdata_d     = '0;
               mem_req_d   = 1'b0;
               if_rvalid_d = (state_q == S_BUSY_IF);
               ls_rvalid_d = (state_q == S_BUSY_LS);
               err_d       = 1'b1;
               state_d     = S_IDLE;
            end else begin
               to_d = to_q + 1'b1;
            end
`endif
         end
         default: begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset abandons any transfer in flight.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         starve_q    <= '0;
         if_gnt_q    <= 1'b0;
         ls_gnt_q    <= 1'b0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         rdata_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
`ifdef PRIRV32_ARB_TIMEOUT_EN
         to_q        <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         if_gnt_q    <= if_gnt_d;
         ls_gnt_q    <= ls_gnt_d;
         if_rvalid_q <= if_rvalid_d;
         ls_rvalid_q <= ls_rvalid_d;
         rdata_q     <= rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
`ifdef PRIRV32_ARB_TIMEOUT_EN
         to_q        <= to_d;
         err_q       <= err_d;
`endif
      end
   end

   assign if_gnt_o    = if_gnt_q;
   assign ls_gnt_o    = ls_gnt_q;
   assign if_rvalid_o = if_rvalid_q;
   assign ls_rvalid_o = ls_rvalid_q;
   assign rdata_o     = rdata_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_be_o    = mem_be_q;
`ifdef PRIRV32_ARB_TIMEOUT_EN
   assign err_o       = err_q;
`else
   assign err_o       = 1'b0;
`endif

endmodule
